// File: rtl/led_display_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_display_capture_if
//  Brief    : Row hand-off bus between the LED capture block and its consumer.
//             master = capture side (drives the row), slave = checker/logger.
//  Revision : 1.0 - initial release
// ============================================================================
interface led_display_capture_if #(
    parameter int NUM_COLS = 64
);
    logic                    row_valid_out;
    logic                    row_ready_in;
    logic [3:0]              row_addr_out;
    logic [3*NUM_COLS-1:0]   row_top_out;
    logic [3*NUM_COLS-1:0]   row_bot_out;
    logic                    row_len_err_out;
    logic                    row_oe_err_out;

    modport master (
        output row_valid_out,
        output row_addr_out,
        output row_top_out,
        output row_bot_out,
        output row_len_err_out,
        output row_oe_err_out,
        input  row_ready_in
    );

    modport slave (
        input  row_valid_out,
        input  row_addr_out,
        input  row_top_out,
        input  row_bot_out,
        input  row_len_err_out,
        input  row_oe_err_out,
        output row_ready_in
    );
endinterface
`default_nettype wire

// File: rtl/led_display_capture.sv
`default_nettype none
// ============================================================================
//  Module   : led_display_capture
//  Brief    : HUB75 receive-side monitor. Oversamples the matrix pins with
//             clk_in, rebuilds each shifted row into colour planes and hands
//             it out over a single-entry valid/ready buffer.
//  Options  : LED_CAPTURE_FRAME_STATS_EN adds frame_count_out / frame_err_out.
//  Revision : 1.0 - initial release
// ============================================================================
module led_display_capture #(
    parameter int NUM_COLS    = 64,
    parameter int NUM_ADDR    = 16,
    parameter int SYNC_STAGES = 2     // must be >= 2
) (
    input  wire                   clk_in,
    input  wire                   n_reset_in,
    input  wire                   bit_clk_in,
    input  wire [2:0]             rgb_top_in,
    input  wire [2:0]             rgb_bot_in,
    input  wire                   latch_enable_in,
    input  wire                   output_enable_in,
    input  wire [3:0]             addr_in,
    led_display_capture_if.master row_if,
    input  wire                   status_clear_in,
    output logic                  overflow_out
`ifdef LED_CAPTURE_FRAME_STATS_EN
    ,
    output logic [15:0]           frame_count_out,
    output logic                  frame_err_out
`endif
);

    localparam int COLS_W = $clog2(NUM_COLS + 2);
    localparam int PIN_W  = 13;
    localparam int PW     = 3 * NUM_COLS;

    localparam logic [COLS_W-1:0] COL_LIMIT = COLS_W'(NUM_COLS);
    localparam logic [COLS_W-1:0] COL_SAT   = COLS_W'(NUM_COLS + 1);

    typedef enum logic [0:0] {
        ST_SYNC  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Pin bundle: {bit_clk, latch, oe, addr[3:0], top[2:0], bot[2:0]}
    logic [PIN_W-1:0] pins_w;
    logic [PIN_W-1:0] sync_q [SYNC_STAGES];
    logic [PIN_W-1:0] sync_d [SYNC_STAGES];
    logic [PIN_W-1:0] sync_w;
    logic [1:0]       prev_clk_q, prev_clk_d;
    logic [PIN_W-1:0] det_q, det_d;

    logic             bclk_rise_w, latch_rise_w, oe_w;
    logic [3:0]       addr_w;
    logic [2:0]       top_w, bot_w;

    state_t              state_q, state_d;
    logic [COLS_W-1:0]   col_cnt_q, col_cnt_d;
    logic [PW-1:0]       top_plane_q, top_plane_d;
    logic [PW-1:0]       bot_plane_q, bot_plane_d;

    logic                close_w, load_w, close_len_err_w;
    logic [PW-1:0]       close_top_w, close_bot_w;

    logic                valid_q, valid_d;
    logic [3:0]          out_addr_q, out_addr_d;
    logic [PW-1:0]       out_top_q, out_top_d;
    logic [PW-1:0]       out_bot_q, out_bot_d;
    logic                len_err_q, len_err_d;
    logic                oe_err_q, oe_err_d;
    logic                overflow_q, overflow_d;

    assign pins_w = {bit_clk_in, latch_enable_in, output_enable_in,
                     addr_in, rgb_top_in, rgb_bot_in};
    assign sync_w = sync_q[SYNC_STAGES-1];

    // Synchroniser chain (all pins move together) plus edge-detect stage
    always_comb begin
        sync_d[0] = pins_w;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_clk_d = sync_w[12:11];
        // Rise flags are registered together with the data they qualify
        det_d = {sync_w[12] & ~prev_clk_q[1],
                 sync_w[11] & ~prev_clk_q[0],
                 sync_w[10:0]};
    end

    assign bclk_rise_w  = det_q[12];
    assign latch_rise_w = det_q[11];
    assign oe_w         = det_q[10];
    assign addr_w       = det_q[9:6];
    assign top_w        = det_q[5:3];
    assign bot_w        = det_q[2:0];

    // FSM state register
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: store the bit first, then close the row so a same-cycle
    // bit/latch pair lands inside the closing row
    always_comb begin
        state_d         = state_q;
        col_cnt_d       = col_cnt_q;
        top_plane_d     = top_plane_q;
        bot_plane_d     = bot_plane_q;
        close_w         = 1'b0;
        close_len_err_w = 1'b0;
        close_top_w     = '0;
        close_bot_w     = '0;
        case (state_q)
            ST_SYNC: begin
                if (latch_rise_w) begin
                    state_d     = ST_SHIFT;
                    col_cnt_d   = '0;
                    top_plane_d = '0;
                    bot_plane_d = '0;
                end
            end
            ST_SHIFT: begin
                if (bclk_rise_w) begin
                    // Only columns 0..NUM_COLS-1 match, so surplus bits fall away
                    for (int c = 0; c < NUM_COLS; c++) begin
                        if (col_cnt_q == COLS_W'(c)) begin
                            for (int j = 0; j < 3; j++) begin
                                top_plane_d[j*NUM_COLS + c] = top_w[j];
                                bot_plane_d[j*NUM_COLS + c] = bot_w[j];
                            end
                        end
                    end
                    if (col_cnt_q != COL_SAT) begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
                if (latch_rise_w) begin
                    close_w         = 1'b1;
                    close_len_err_w = (col_cnt_d != COL_LIMIT);
                    close_top_w     = top_plane_d;
                    close_bot_w     = bot_plane_d;
                    col_cnt_d       = '0;
                    top_plane_d     = '0;
                    bot_plane_d     = '0;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // Single-entry output buffer; a close into a stuck buffer drops the new row
    always_comb begin
        valid_d    = valid_q & ~row_if.row_ready_in;
        out_addr_d = out_addr_q;
        out_top_d  = out_top_q;
        out_bot_d  = out_bot_q;
        len_err_d  = len_err_q;
        oe_err_d   = oe_err_q;
        overflow_d = overflow_q;
        load_w     = close_w & (~valid_q | row_if.row_ready_in);
        if (status_clear_in) begin
            overflow_d = 1'b0;
        end
        if (load_w) begin
            valid_d    = 1'b1;
            out_addr_d = addr_w;
            out_top_d  = close_top_w;
            out_bot_d  = close_bot_w;
            len_err_d  = close_len_err_w;
            oe_err_d   = ~oe_w;
        end
        if (close_w && !load_w) begin
            overflow_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_clk_q  <= '0;
            det_q       <= '0;
            col_cnt_q   <= '0;
            top_plane_q <= '0;
            bot_plane_q <= '0;
            valid_q     <= 1'b0;
            out_addr_q  <= '0;
            out_top_q   <= '0;
            out_bot_q   <= '0;
            len_err_q   <= 1'b0;
            oe_err_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_clk_q  <= prev_clk_d;
            det_q       <= det_d;
            col_cnt_q   <= col_cnt_d;
            top_plane_q <= top_plane_d;
            bot_plane_q <= bot_plane_d;
            valid_q     <= valid_d;
            out_addr_q  <= out_addr_d;
            out_top_q   <= out_top_d;
            out_bot_q   <= out_bot_d;
            len_err_q   <= len_err_d;
            oe_err_q    <= oe_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign row_if.row_valid_out   = valid_q;
    assign row_if.row_addr_out    = out_addr_q;
    assign row_if.row_top_out     = out_top_q;
    assign row_if.row_bot_out     = out_bot_q;
    assign row_if.row_len_err_out = len_err_q;
    assign row_if.row_oe_err_out  = oe_err_q;
    assign overflow_out           = overflow_q;

`ifdef LED_CAPTURE_FRAME_STATS_EN
    localparam logic [3:0] LAST_ADDR = 4'(NUM_ADDR - 1);

    logic [15:0] frame_count_q, frame_count_d;
    logic        frame_err_q, frame_err_d;
    logic [3:0]  prev_addr_q, prev_addr_d;
    logic        have_prev_q, have_prev_d;
    logic [3:0]  next_addr_w;

    assign next_addr_w = (prev_addr_q == LAST_ADDR) ? 4'd0 : prev_addr_q + 4'd1;

    // Frame tracking: wrap from last address to 0 counts a frame, any other
    // non-sequential address is an error; clear applies before a new event
    always_comb begin
        frame_count_d = frame_count_q;
        frame_err_d   = frame_err_q;
        prev_addr_d   = prev_addr_q;
        have_prev_d   = have_prev_q;
        if (status_clear_in) begin
            frame_count_d = '0;
            frame_err_d   = 1'b0;
        end
        if (close_w) begin
            if (have_prev_q && (addr_w != next_addr_w)) begin
                frame_err_d = 1'b1;
            end
            if (load_w && have_prev_q && (addr_w == 4'd0) && (prev_addr_q == LAST_ADDR)) begin
                frame_count_d = frame_count_d + 16'd1;
            end
            prev_addr_d = addr_w;
            have_prev_d = 1'b1;
        end
    end

    // Frame statistics registers
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            frame_count_q <= '0;
            frame_err_q   <= 1'b0;
            prev_addr_q   <= '0;
            have_prev_q   <= 1'b0;
        end else begin
            frame_count_q <= frame_count_d;
            frame_err_q   <= frame_err_d;
            prev_addr_q   <= prev_addr_d;
            have_prev_q   <= have_prev_d;
        end
    end

    assign frame_count_out = frame_count_q;
    assign frame_err_out   = frame_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_display_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_display_capture
//  Brief    : Directed bench for led_display_capture with a row scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_display_capture;

    localparam int NC = 64;
    localparam int NA = 16;
    localparam int SS = 2;
    localparam int PW = 3 * NC;

    logic       clk_in = 1'b0;
    logic       n_reset_in;
    logic       bit_clk_in;
    logic [2:0] rgb_top_in;
    logic [2:0] rgb_bot_in;
    logic       latch_enable_in;
    logic       output_enable_in;
    logic [3:0] addr_in;
    logic       status_clear_in;
    logic       overflow_out;
`ifdef LED_CAPTURE_FRAME_STATS_EN
    logic [15:0] frame_count_out;
    logic        frame_err_out;
`endif

    led_display_capture_if #(.NUM_COLS(NC)) row_bus ();

    led_display_capture #(
        .NUM_COLS    (NC),
        .NUM_ADDR    (NA),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_in           (clk_in),
        .n_reset_in       (n_reset_in),
        .bit_clk_in       (bit_clk_in),
        .rgb_top_in       (rgb_top_in),
        .rgb_bot_in       (rgb_bot_in),
        .latch_enable_in  (latch_enable_in),
        .output_enable_in (output_enable_in),
        .addr_in          (addr_in),
        .row_if           (row_bus),
        .status_clear_in  (status_clear_in),
        .overflow_out     (overflow_out)
`ifdef LED_CAPTURE_FRAME_STATS_EN
        ,
        .frame_count_out  (frame_count_out),
        .frame_err_out    (frame_err_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0]    addr;
        logic [PW-1:0] top;
        logic [PW-1:0] bot;
        logic          len_err;
        logic          oe_err;
    } row_t;

    row_t          exp_q[$];
    int            total = 0;
    int            bad   = 0;
    logic [PW-1:0] m_top;
    logic [PW-1:0] m_bot;
    int            m_cnt;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_top = '0;
        m_bot = '0;
        m_cnt = 0;
    endtask

    // One bit-clock period: 4 cycles high, 4 low
    task automatic shift_bit(input logic [2:0] t, input logic [2:0] b);
        @(negedge clk_in);
        rgb_top_in = t;
        rgb_bot_in = b;
        bit_clk_in = 1'b1;
        if (m_cnt < NC) begin
            for (int j = 0; j < 3; j++) begin
                m_top[j*NC + m_cnt] = t[j];
                m_bot[j*NC + m_cnt] = b[j];
            end
        end
        m_cnt++;
        repeat (4) @(negedge clk_in);
        bit_clk_in = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic shift_random(input int n);
        for (int i = 0; i < n; i++) begin
            shift_bit(3'($urandom), 3'($urandom));
        end
    endtask

    // Latch pulse; optionally drives ready/clear in the cycle the row loads
    task automatic latch_row(input logic [3:0] a, input logic oe, input bit push,
                             input bit check_lat, input bit ready_on_load,
                             input bit clear_on_load);
        int seen;
        row_t r;
        @(negedge clk_in);
        addr_in          = a;
        output_enable_in = oe;
        latch_enable_in  = 1'b1;
        if (push) begin
            r.addr    = a;
            r.top     = m_top;
            r.bot     = m_bot;
            r.len_err = (m_cnt != NC);
            r.oe_err  = !oe;
            exp_q.push_back(r);
        end
        model_clear();
        seen = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_in);
            if (k == 3) begin
                row_bus.row_ready_in = ready_on_load;
                status_clear_in      = clear_on_load;
            end
            if (k == 4) begin
                row_bus.row_ready_in = 1'b0;
                status_clear_in      = 1'b0;
            end
            if (check_lat && seen == 0 && row_bus.row_valid_out === 1'b1) seen = k;
        end
        latch_enable_in = 1'b0;
        if (check_lat) check("latency", PW'(seen), PW'(SS + 2));
        repeat (4) @(negedge clk_in);
    endtask

    task automatic check_head(input string tag);
        row_t e;
        int n;
        n = 0;
        while (row_bus.row_valid_out !== 1'b1 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        check({tag, "_valid"}, PW'(row_bus.row_valid_out), PW'(1'b1));
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s_scoreboard: got empty queue want an entry", tag);
        end else begin
            e = exp_q[0];
            check({tag, "_addr"}, PW'(row_bus.row_addr_out), PW'(e.addr));
            check({tag, "_top"}, row_bus.row_top_out, e.top);
            check({tag, "_bot"}, row_bus.row_bot_out, e.bot);
            check({tag, "_len_err"}, PW'(row_bus.row_len_err_out), PW'(e.len_err));
            check({tag, "_oe_err"}, PW'(row_bus.row_oe_err_out), PW'(e.oe_err));
        end
    endtask

    task automatic consume(input string tag);
        check_head(tag);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        row_bus.row_ready_in = 1'b1;
        @(negedge clk_in);
        row_bus.row_ready_in = 1'b0;
        check({tag, "_drained"}, PW'(row_bus.row_valid_out), PW'(1'b0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, PW'(row_bus.row_valid_out), '0);
        check({tag, "_addr"}, PW'(row_bus.row_addr_out), '0);
        check({tag, "_top"}, row_bus.row_top_out, '0);
        check({tag, "_bot"}, row_bus.row_bot_out, '0);
        check({tag, "_len_err"}, PW'(row_bus.row_len_err_out), '0);
        check({tag, "_oe_err"}, PW'(row_bus.row_oe_err_out), '0);
        check({tag, "_overflow"}, PW'(overflow_out), '0);
`ifdef LED_CAPTURE_FRAME_STATS_EN
        check({tag, "_frame_count"}, PW'(frame_count_out), '0);
        check({tag, "_frame_err"}, PW'(frame_err_out), '0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] exp_v;

        n_reset_in           = 1'b0;
        bit_clk_in           = 1'b0;
        rgb_top_in           = '0;
        rgb_bot_in           = '0;
        latch_enable_in      = 1'b0;
        output_enable_in     = 1'b1;
        addr_in              = '0;
        status_clear_in      = 1'b0;
        row_bus.row_ready_in = 1'b0;
        model_clear();

        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        n_reset_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // Dummy latch only arms the capture
        shift_random(3);
        latch_row(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("dummy_no_row", PW'(row_bus.row_valid_out), '0);

        // Basic row: red top plane, blue bottom plane
        for (int c = 0; c < NC; c++) shift_bit(3'b100, 3'b001);
        latch_row(4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("basic_red_top", row_bus.row_top_out >> (2*NC), {{(PW-NC){1'b0}}, {NC{1'b1}}});
        check("basic_blue_bot", row_bus.row_bot_out, {{(PW-NC){1'b0}}, {NC{1'b1}}});
        consume("basic");

        // Column order: only pixel 0 and pixel 63 red
        for (int c = 0; c < NC; c++) shift_bit((c == 0 || c == NC-1) ? 3'b100 : 3'b000, 3'b000);
        latch_row(4'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_v = '0;
        exp_v[2*NC + 0]    = 1'b1;
        exp_v[2*NC + NC-1] = 1'b1;
        check("colorder_top", row_bus.row_top_out, exp_v);
        consume("colorder");

        // Short row with display blanked at the latch
        shift_random(NC - 1);
        latch_row(4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("short_len_err", PW'(row_bus.row_len_err_out), PW'(1'b1));
        check("short_col63", PW'({row_bus.row_top_out[3*NC-1], row_bus.row_top_out[2*NC-1],
                                  row_bus.row_top_out[NC-1]}), '0);
        consume("short");

        // Long row: surplus bits discarded
        shift_random(NC + 2);
        latch_row(4'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("long_len_err", PW'(row_bus.row_len_err_out), PW'(1'b1));
        consume("long");

        // Backpressure: second row dropped, first held
        shift_random(NC);
        latch_row(4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        shift_random(NC);
        latch_row(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_addr_held", PW'(row_bus.row_addr_out), PW'(4'd1));
        check("bp_overflow", PW'(overflow_out), PW'(1'b1));
        @(negedge clk_in);
        status_clear_in = 1'b1;
        @(negedge clk_in);
        status_clear_in = 1'b0;
        check("bp_overflow_cleared", PW'(overflow_out), '0);
        // Clear and drop in the same cycle: set wins
        shift_random(4);
        latch_row(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("bp_set_wins", PW'(overflow_out), PW'(1'b1));
        @(negedge clk_in);
        status_clear_in = 1'b1;
        @(negedge clk_in);
        status_clear_in = 1'b0;
        consume("bp");

        // Consume and load in the same cycle
        shift_random(NC);
        latch_row(4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_head("same_first");
        shift_random(NC);
        latch_row(4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        check("same_valid_kept", PW'(row_bus.row_valid_out), PW'(1'b1));
        check("same_addr_next", PW'(row_bus.row_addr_out), PW'(4'd2));
        check("same_no_overflow", PW'(overflow_out), '0);
        consume("same");

        // Reset in the middle of a row with a row still buffered
        shift_random(NC);
        latch_row(4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        shift_random(30);
        @(negedge clk_in);
        n_reset_in = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        model_clear();
        repeat (3) @(negedge clk_in);
        n_reset_in = 1'b1;
        repeat (2) @(negedge clk_in);
        shift_random(5);
        latch_row(4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk_in);
        check("post_reset_no_row", PW'(row_bus.row_valid_out), '0);

        // Full row at address 0 then a short-row frame 1..15,0
        shift_random(NC);
        latch_row(4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        consume("post_reset");
        for (int a = 1; a <= NA; a++) begin
            shift_random(4);
            latch_row(4'(a % NA), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            consume("frame_row");
        end
`ifdef LED_CAPTURE_FRAME_STATS_EN
        check("frame_count", PW'(frame_count_out), PW'(16'd1));
        check("frame_err", PW'(frame_err_out), '0);
        shift_random(2);
        latch_row(4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        consume("frame_skip");
        check("frame_err_set", PW'(frame_err_out), PW'(1'b1));
        @(negedge clk_in);
        status_clear_in = 1'b1;
        @(negedge clk_in);
        status_clear_in = 1'b0;
        check("frame_count_clr", PW'(frame_count_out), '0);
        check("frame_err_clr", PW'(frame_err_out), '0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
